// File: rtl/matrix_multiply_unit.sv
// rtl/matrix_multiply_unit.sv - combinational C = A x B on packed up-to-5x5 8-bit matrices
module matrix_multiply_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   a_m,
  input  logic [2:0]   a_n,
  input  logic [2:0]   b_m,
  input  logic [2:0]   b_n,
  input  logic [399:0] matrices_in,
  output logic [2:0]   c_m,
  output logic [2:0]   c_n,
  output logic [399:0] matrices_out,
  output logic         valid
);

  localparam int DIM_MAX = 5;
  localparam int ELEM_W  = 8;
  localparam int SLOT_W  = DIM_MAX * DIM_MAX * ELEM_W;

  // clk only exists so this unit drops into the shared datapath port list
  logic unused_clk;
  assign unused_clk = clk;

  logic              dims_ok;
  logic [399:0]      prod_bus;
  logic [ELEM_W-1:0] a_elem;
  logic [ELEM_W-1:0] b_elem;
  logic [15:0]       prod;
  logic [ELEM_W-1:0] acc;

  function automatic logic dim_legal(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd5);
  endfunction

  assign dims_ok = (a_n == b_m) && dim_legal(a_m) && dim_legal(a_n)
                   && dim_legal(b_m) && dim_legal(b_n);

  // Out-of-range terms are masked so stale data in unused slots never leaks in
  always_comb begin
    prod_bus = '0;
    a_elem   = '0;
    b_elem   = '0;
    prod     = '0;
    acc      = '0;
    for (int i = 0; i < DIM_MAX; i++) begin
      for (int j = 0; j < DIM_MAX; j++) begin
        acc = '0;
        for (int k = 0; k < DIM_MAX; k++) begin
          a_elem = matrices_in[(i*DIM_MAX + k)*ELEM_W +: ELEM_W];
          b_elem = matrices_in[SLOT_W + (k*DIM_MAX + j)*ELEM_W +: ELEM_W];
          prod   = 16'(a_elem) * 16'(b_elem);
          if ((3'(k) < a_n) && (3'(i) < a_m) && (3'(j) < b_n)) begin
            acc = acc + prod[ELEM_W-1:0];
          end
        end
        if ((3'(i) < a_m) && (3'(j) < b_n)) begin
          prod_bus[(i*DIM_MAX + j)*ELEM_W +: ELEM_W] = acc;
        end
      end
    end
  end

  // Reset gates the outputs directly, so release shows the live result without a clock edge
  always_comb begin
    valid        = 1'b0;
    c_m          = '0;
    c_n          = '0;
    matrices_out = '0;
    if (!reset && dims_ok) begin
      valid        = 1'b1;
      c_m          = a_m;
      c_n          = b_n;
      matrices_out = prod_bus;
    end
  end

endmodule

// File: tb/tb_matrix_multiply_unit.sv
// tb/tb_matrix_multiply_unit.sv - self-checking bench for matrix_multiply_unit
module tb_matrix_multiply_unit;

  logic         clk;
  logic         clk_run;
  logic         reset;
  logic [2:0]   a_m, a_n, b_m, b_n;
  logic [399:0] matrices_in;
  logic [2:0]   c_m, c_n;
  logic [399:0] matrices_out;
  logic         valid;

  int cmps;
  int errs;

  matrix_multiply_unit dut (
    .clk          (clk),
    .reset        (reset),
    .a_m          (a_m),
    .a_n          (a_n),
    .b_m          (b_m),
    .b_n          (b_n),
    .matrices_in  (matrices_in),
    .c_m          (c_m),
    .c_n          (c_n),
    .matrices_out (matrices_out),
    .valid        (valid)
  );

  always begin
    #5;
    clk = clk_run ? ~clk : 1'b0;
  end

  task automatic put(input int s, input int r, input int c, input int v);
    matrices_in[s*200 + (r*5 + c)*8 +: 8] = 8'(v);
  endtask

  function automatic logic [399:0] place(input logic [399:0] bus, input int r, input int c, input int v);
    logic [399:0] t;
    t = bus;
    t[(r*5 + c)*8 +: 8] = 8'(v);
    return t;
  endfunction

  // Reference: unpack to integer matrices, textbook triple sum, reduce mod 256
  task automatic model(output logic [406:0] exp_all);
    int A[5][5];
    int B[5][5];
    int m, n, bm, bn, s;
    logic ev;
    logic [399:0] eo;
    m = int'(a_m); n = int'(a_n); bm = int'(b_m); bn = int'(b_n);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        A[r][c] = int'(matrices_in[(r*5 + c)*8 +: 8]);
        B[r][c] = int'(matrices_in[200 + (r*5 + c)*8 +: 8]);
      end
    ev = (n == bm) && m >= 1 && m <= 5 && n >= 1 && n <= 5 && bm >= 1 && bm <= 5 && bn >= 1 && bn <= 5;
    eo = '0;
    if (ev) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < bn; j++) begin
          s = 0;
          for (int k = 0; k < n; k++) s += A[i][k] * B[k][j];
          eo = place(eo, i, j, s % 256);
        end
      exp_all = {ev, a_m, b_n, eo};
    end else begin
      exp_all = {1'b0, 3'd0, 3'd0, eo};
    end
  endtask

  task automatic set_dims(input int am, input int an, input int bm, input int bn);
    a_m = 3'(am); a_n = 3'(an); b_m = 3'(bm); b_n = 3'(bn);
  endtask

  task automatic randomize_data;
    for (int w = 0; w < 13; w++) matrices_in[w*32 +: 32] = $urandom;
    // bits above 399 fall off; the final word only supplies bits 384..399
  endtask

  task automatic test_reset;
    clk_run = 1'b1;
    reset = 1'b1;
    set_dims(3, 3, 3, 3);
    randomize_data();
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== 407'd0) begin
      errs++;
      $display("FAIL reset_outputs: got valid=%0b c=%0dx%0d out=%h, want all zero", valid, c_m, c_n, matrices_out);
    end
    @(posedge clk); #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== 407'd0) begin
      errs++;
      $display("FAIL reset_after_edge: got valid=%0b c=%0dx%0d out=%h, want all zero", valid, c_m, c_n, matrices_out);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_example;
    logic [399:0] want;
    clk_run = 1'b0;
    #20;
    matrices_in = '0;
    set_dims(2, 3, 3, 2);
    put(0,0,0,1); put(0,0,1,2); put(0,0,2,3);
    put(0,1,0,3); put(0,1,1,4); put(0,1,2,5);
    put(1,0,0,1); put(1,0,1,0);
    put(1,1,0,2); put(1,1,1,1);
    put(1,2,0,3); put(1,2,1,2);
    want = '0;
    want = place(want,0,0,14); want = place(want,0,1,8);
    want = place(want,1,0,26); want = place(want,1,1,14);
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== {1'b1, 3'd2, 3'd2, want}) begin
      errs++;
      $display("FAIL example_2x3x2: got valid=%0b c=%0dx%0d out=%h, want valid=1 c=2x2 out=%h", valid, c_m, c_n, matrices_out, want);
    end
    clk_run = 1'b1;
  endtask

  task automatic test_invalid;
    randomize_data();
    set_dims(2, 3, 2, 4);
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== 407'd0) begin
      errs++;
      $display("FAIL invalid_mismatch: got valid=%0b c=%0dx%0d out=%h, want all zero", valid, c_m, c_n, matrices_out);
    end
    for (int d = 0; d < 3; d++) begin
      set_dims(d == 0 ? 0 : 3, 3, 3, d == 0 ? 3 : (d == 1 ? 6 : 7));
      #1;
      cmps++;
      if ({valid, c_m, c_n, matrices_out} !== 407'd0) begin
        errs++;
        $display("FAIL invalid_range_%0d: got valid=%0b c=%0dx%0d out=%h, want all zero", d, valid, c_m, c_n, matrices_out);
      end
    end
  endtask

  task automatic test_trunc_1x1;
    randomize_data();
    put(0,0,0,16); put(1,0,0,17);
    set_dims(1, 1, 1, 1);
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== {1'b1, 3'd1, 3'd1, 392'd0, 8'd16}) begin
      errs++;
      $display("FAIL trunc_1x1: got valid=%0b c=%0dx%0d out=%h, want valid=1 c=1x1 C00=16", valid, c_m, c_n, matrices_out);
    end
  endtask

  task automatic test_full_ones;
    logic [399:0] want;
    want = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        put(0, r, c, 1); put(1, r, c, 1);
        want = place(want, r, c, 5);
      end
    set_dims(5, 5, 5, 5);
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== {1'b1, 3'd5, 3'd5, want}) begin
      errs++;
      $display("FAIL full_ones_5x5: got valid=%0b c=%0dx%0d out=%h, want valid=1 c=5x5 out=%h", valid, c_m, c_n, matrices_out, want);
    end
  endtask

  task automatic test_identity_garbage;
    logic [399:0] want;
    int av[4];
    matrices_in = {400{1'b1}};
    for (int i = 0; i < 4; i++) av[i] = int'($urandom_range(0, 255));
    put(0,0,0,av[0]); put(0,0,1,av[1]); put(0,1,0,av[2]); put(0,1,1,av[3]);
    put(1,0,0,1); put(1,0,1,0); put(1,1,0,0); put(1,1,1,1);
    want = '0;
    want = place(want,0,0,av[0]); want = place(want,0,1,av[1]);
    want = place(want,1,0,av[2]); want = place(want,1,1,av[3]);
    set_dims(2, 2, 2, 2);
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== {1'b1, 3'd2, 3'd2, want}) begin
      errs++;
      $display("FAIL identity_garbage: got valid=%0b c=%0dx%0d out=%h, want valid=1 c=2x2 out=%h", valid, c_m, c_n, matrices_out, want);
    end
  endtask

  task automatic test_reset_midstream;
    logic [406:0] exp_all;
    randomize_data();
    set_dims(3, 4, 4, 2);
    clk_run = 1'b0;
    #20;
    model(exp_all);
    reset = 1'b1;
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== 407'd0) begin
      errs++;
      $display("FAIL reset_mid_assert: got valid=%0b c=%0dx%0d out=%h, want all zero", valid, c_m, c_n, matrices_out);
    end
    reset = 1'b0;
    #1;
    cmps++;
    if ({valid, c_m, c_n, matrices_out} !== exp_all) begin
      errs++;
      $display("FAIL reset_mid_release: got %h, want %h", {valid, c_m, c_n, matrices_out}, exp_all);
    end
    clk_run = 1'b1;
  endtask

  task automatic test_random;
    logic [406:0] exp_all;
    int an;
    for (int t = 0; t < 300; t++) begin
      randomize_data();
      an = int'($urandom_range(1, 5));
      set_dims(int'($urandom_range(1, 5)), an, an, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 4) == 0) begin
        set_dims(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      @(negedge clk);
      model(exp_all);
      cmps++;
      if ({valid, c_m, c_n, matrices_out} !== exp_all) begin
        errs++;
        $display("FAIL random_%0d dims=%0dx%0d*%0dx%0d: got %h, want %h", t, a_m, a_n, b_m, b_n, {valid, c_m, c_n, matrices_out}, exp_all);
      end
    end
  endtask

  initial begin
    cmps = 0;
    errs = 0;
    clk = 1'b0;
    clk_run = 1'b0;
    reset = 1'b1;
    matrices_in = '0;
    set_dims(0, 0, 0, 0);
    test_reset();
    test_example();
    test_invalid();
    test_trunc_1x1();
    test_full_ones();
    test_identity_garbage();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
